dmem_responder: RTL
===================

# dmem_responder

Multi-cycle data-memory responder for the pipelined ARM core. It serves the data side of the load/store interface: the core issues word reads and writes, and this block returns data after a fixed, programmable latency. It drives a `stall` signal to the core's hazard unit so the memory stage freezes until the access completes. It replaces the zero-latency `dmem` in `top` when slower memory is modelled.

## Interface
Parameters:
- `DEPTH`, 64: number of 32-bit words; must be a power of 2.
- `LATENCY`, 2: wait cycles per access; legal range 1..15.

Ports:
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `req` in 1: access request, held by the core while `stall`=1.
- `wr_en` in 1: 1 = write, 0 = read; held with `req`.
- `addr` in 32: byte address; held with `req`.
- `wr_data` in 32: write data; held with `req`.
- `rd_data` out 32: read result; registered.
- `ack` out 1: one-cycle completion pulse.
- `stall` out 1: freeze request to the core's hazard unit; combinational.
- `err` out 1: access fault, valid while `ack`=1.

## Operation
- Three-state FSM:
  - IDLE → WAIT when `req`=1. This edge captures `addr`, `wr_en` and `wr_data` into internal registers and loads `cnt` with `LATENCY-1`.
  - WAIT: while `cnt`≠0, `cnt` decrements. When `cnt`=0, the access commits at that edge and the FSM goes to DONE.
  - DONE → IDLE unconditionally.
- Commit on a write: `mem[idx]` is written from the captured `wr_data`; `rd_data` is unchanged.
- Commit on a read: `rd_data` is loaded with `mem[idx]`.
- Word index: `idx` = captured `addr[log2(DEPTH)+1:2]`.
- `stall` = (IDLE & `req`) | WAIT. It is 0 in DONE.
- `ack` = 1 only in DONE.
- `rd_data` holds its value between reads.
- The block uses only the captured copies of the inputs. If `req` drops during WAIT, the access still completes and `ack` still pulses.
- A `req` seen in DONE is ignored. It is accepted the next cycle in IDLE, so there is exactly one bubble between back-to-back requests.
- Reset:
  - FSM → IDLE, `cnt`=0.
  - `rd_data`=0, `ack`=0, `err`=0, `stall`=0 (given `req`=0).
  - Memory contents are not cleared.
  - Reset during WAIT aborts the transaction: no write occurs, because commit happens only at WAIT exit.

## Timing
- `req` first seen in cycle 0:
  - `stall` is high in cycles 0..`LATENCY`.
  - `ack`=1 in cycle `LATENCY`+1.
  - The core advances at the end of cycle `LATENCY`+1.
- Read data is valid in the `ack` cycle and stays until the next read commit.
- Next request can be accepted in cycle `LATENCY`+2 at the earliest.
- `LATENCY`=1: `stall` is high in cycles 0–1 and `ack` is in cycle 2.

## Configuration
- Macro `DMEM_ERR_EN` defined:
  - An access faults if captured `addr[1:0]`≠0 or `addr` ≥ `DEPTH`*4.
  - A faulting write is dropped.
  - A faulting read loads `rd_data`=0.
  - `err`=1 in the `ack` cycle.
- Macro `DMEM_ERR_EN` not defined:
  - `err` is tied to 0.
  - `addr[1:0]` is ignored.
  - Upper address bits are ignored, so the index wraps modulo `DEPTH`.

## Structure
- Package `dmem_pkg` holds:
  - the state enum `dmem_state_t` {IDLE, WAIT, DONE};
  - `DATA_W`=32 and `ADDR_W`=32;
  - the `cnt` width constant (4).
- Sub-module `dmem_array`: synchronous-write word array of `DEPTH`×32 with a read port. `dmem_responder` instantiates it and owns the FSM, capture registers and error check.

## Test plan
1. `LATENCY`=2. Write 0xDEADBEEF to 0x10, `req` in cycle 0 → `stall`=1 in cycles 0–2, `ack`=1 in cycle 3, `rd_data` unchanged (0).
2. Read 0x10 after test 1 → `ack` cycle shows `rd_data`=0xDEADBEEF, `err`=0. `rd_data` holds after `req` drops.
3. Back-to-back: write 0x1 to 0x0, then read 0x0 held continuously → the second access is accepted one cycle after the first `ack` and returns 0x1. Exactly one `ack` per access.
4. Assert `rst` during WAIT of a write of 0x55 to 0x20 → next cycle state is IDLE, `stall`=0, `ack` never pulses. A later read of 0x20 returns the prior value.
5. `DMEM_ERR_EN`: read 0x13 → `err`=1 with `ack`, `rd_data`=0. Write to 0x100 with `DEPTH`=64 → `err`=1, no array write. Without the macro, a write to 0x104 lands in word 1 (wrap).
6. Drop `req` in the cycle after acceptance → the access completes and `ack` still pulses at cycle `LATENCY`+1.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// dmem_pkg: shared types and widths for the multi-cycle data-memory responder.
`default_nettype none

package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32 word array, synchronous write, asynchronous read port.
`default_nettype none

module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wr_data;
    end
  end

  assign rd_data = mem[idx];

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency load/store responder with core stall output.
// Define DMEM_ERR_EN to fault misaligned or out-of-range accesses.
`default_nettype none

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              ack,
  output logic              stall,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH);

  dmem_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  cap_idx;
  logic              cap_wr;
  logic [DATA_W-1:0] cap_data;
  logic              cap_fault;
  logic              fault_now;
  logic              commit;
  logic              arr_we;
  logic [DATA_W-1:0] arr_rd;

`ifdef DMEM_ERR_EN
  assign fault_now = (addr[1:0] != 2'b00) || (addr >= ADDR_W'(DEPTH * 4));
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[ADDR_W-1:IDX_W+2], addr[1:0]};
  assign fault_now        = 1'b0;
`endif

  assign stall  = ((state == IDLE) && req) || (state == WAIT);
  assign commit = (state == WAIT) && (cnt == '0);
  // A reset coinciding with the commit edge must abort the write as well.
  assign arr_we = commit && cap_wr && !cap_fault && !rst;

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .we      (arr_we),
    .idx     (cap_idx),
    .wr_data (cap_data),
    .rd_data (arr_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_idx   <= '0;
      cap_wr    <= 1'b0;
      cap_data  <= '0;
      cap_fault <= 1'b0;
      rd_data   <= '0;
      ack       <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack <= 1'b0;
          err <= 1'b0;
          if (req) begin
            cap_idx   <= addr[IDX_W+1:2];
            cap_wr    <= wr_en;
            cap_data  <= wr_data;
            cap_fault <= fault_now;
            cnt       <= CNT_W'(LATENCY - 1);
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= DONE;
            ack   <= 1'b1;
            err   <= cap_fault;
            if (!cap_wr) begin
              rd_data <= cap_fault ? '0 : arr_rd;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          ack   <= 1'b0;
          err   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ack   <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
